// File: rtl/game_state_controller.sv
// Space Invaders game sequencer: start/pause/win/lose FSM driving the datapath reset/pause, plus BCD score.
// Define GSC_HIGH_SCORE_EN to build the high-score register; otherwise hi_score_bcd is tied to zero.
module game_state_controller #(
    parameter int unsigned RESET_PULSE_CYCLES = 4,
    parameter int unsigned END_FRAMES         = 180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        pause_btn,
    input  logic        frame_tick,
    input  logic        alien_hit,
    input  logic        game_over,
    input  logic        win,
    output logic        game_rst,
    output logic        game_pause,
    output logic [2:0]  state,
    output logic [11:0] score_bcd,
    output logic [11:0] hi_score_bcd
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    localparam int unsigned CLR_W = $clog2(RESET_PULSE_CYCLES + 1);
    localparam int unsigned FRM_W = $clog2(END_FRAMES + 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(END_FRAMES - 1);

    state_t           state_q, state_d;
    logic [CLR_W-1:0] clr_cnt, clr_cnt_d;
    logic [FRM_W-1:0] frm_cnt, frm_cnt_d;
    logic [11:0]      score_q, score_d;

    // Input sampling stage; an event sampled here acts on the FSM one edge later.
    logic s_start, s_pause, s_hit, s_over, s_win, s_tick;
    logic start_q, pause_q, hit_q;
    logic start_rise, pause_rise, hit_rise;

    assign start_rise = s_start & ~start_q;
    assign pause_rise = s_pause & ~pause_q;
    assign hit_rise   = s_hit   & ~hit_q;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] h, t, u;
        {h, t, u} = v;
        if (v == 12'h999) return v;
        if (u == 4'd9) begin
            u = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            u = u + 4'd1;
        end
        return {h, t, u};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_start <= 1'b1;
            s_pause <= 1'b1;
            s_hit   <= 1'b1;
            s_over  <= 1'b0;
            s_win   <= 1'b0;
            s_tick  <= 1'b0;
            start_q <= 1'b1;
            pause_q <= 1'b1;
            hit_q   <= 1'b1;
        end else begin
            s_start <= start_btn;
            s_pause <= pause_btn;
            s_hit   <= alien_hit;
            s_over  <= game_over;
            s_win   <= win;
            s_tick  <= frame_tick;
            start_q <= s_start;
            pause_q <= s_pause;
            hit_q   <= s_hit;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt;
        frm_cnt_d = frm_cnt;
        score_d   = score_q;
        case (state_q)
            S_IDLE:  if (start_rise) state_d = S_CLEAR;
            S_CLEAR: begin
                if (clr_cnt == CLR_LAST) state_d = S_PLAY;
                else                     clr_cnt_d = clr_cnt + 1'b1;
            end
            S_PLAY: begin
                if (hit_rise) score_d = bcd_inc(score_q);
                if (s_over)          state_d = S_LOSE;
                else if (s_win)      state_d = S_WIN;
                else if (pause_rise) state_d = S_PAUSE;
            end
            S_PAUSE: if (pause_rise) state_d = S_PLAY;
            S_WIN, S_LOSE: begin
                if (start_rise) begin
                    state_d = S_CLEAR;
                end else if (s_tick) begin
                    if (frm_cnt == FRM_LAST) state_d = S_IDLE;
                    else                     frm_cnt_d = frm_cnt + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Entry actions are applied on the transition edge itself.
        if (state_d == S_CLEAR && state_q != S_CLEAR) begin
            clr_cnt_d = '0;
            score_d   = '0;
        end
        if ((state_d == S_WIN || state_d == S_LOSE) && state_q != state_d)
            frm_cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            clr_cnt    <= '0;
            frm_cnt    <= '0;
            score_q    <= '0;
            game_rst   <= 1'b1;
            game_pause <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_cnt    <= clr_cnt_d;
            frm_cnt    <= frm_cnt_d;
            score_q    <= score_d;
            game_rst   <= (state_d == S_IDLE) || (state_d == S_CLEAR);
            game_pause <= (state_d != S_PLAY);
        end
    end

    assign state     = state_q;
    assign score_bcd = score_q;

`ifdef GSC_HIGH_SCORE_EN
    logic [11:0] hi_q, hi_d;

    always_comb begin
        hi_d = hi_q;
        if ((state_d == S_WIN || state_d == S_LOSE) && state_q != state_d && score_d > hi_q)
            hi_d = score_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hi_q <= '0;
        else       hi_q <= hi_d;
    end

    assign hi_score_bcd = hi_q;
`else
    assign hi_score_bcd = 12'h000;
`endif

endmodule
